// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared constants and types for the ALU instruction sequencer.
// Defines the 24-bit instruction layout, the ALU opcode values and the
// sequencer state encoding.
package alu_seq_pkg;

  localparam int INSTR_W   = 24;
  localparam int OPC_LSB   = 22;
  localparam int WADDR_LSB = 19;
  localparam int RADDR_LSB = 16;
  localparam int A_LSB     = 8;
  localparam int B_LSB     = 0;

  localparam logic [1:0] OP_AND  = 2'd0;
  localparam logic [1:0] OP_OR   = 2'd1;
  localparam logic [1:0] OP_NAND = 2'd2;
  localparam logic [1:0] OP_NOR  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} seq_state_t;

  // Field order matches the bit offsets above, MSB first.
  typedef struct packed {
    logic [1:0] opc;
    logic [2:0] waddr;
    logic [2:0] raddr;
    logic [7:0] a;
    logic [7:0] b;
  } instr_t;

endpackage

// File: rtl/alu_instr_sequencer_if.sv
// alu_instr_sequencer_if: all non-clock/reset signals of the sequencer.
//   load_en/load_addr/load_data : program-memory write port
//   start/prog_len              : run request and instruction count
//   busy/done/pc                : run status
//   A/B/opcode/write_addr/write_enable/read_addr : processor control bus
//   step (only with SEQ_STEP_EN): advances EXEC by one instruction
// Modport slave is the sequencer side, master the controlling side.
interface alu_instr_sequencer_if #(parameter int DEPTH = 16);
  localparam int PC_W = $clog2(DEPTH);

  logic              load_en;
  logic [PC_W-1:0]   load_addr;
  logic [23:0]       load_data;
  logic              start;
  logic [PC_W:0]     prog_len;
  logic              busy;
  logic              done;
  logic [PC_W-1:0]   pc;
  logic [7:0]        A;
  logic [7:0]        B;
  logic [1:0]        opcode;
  logic [2:0]        write_addr;
  logic              write_enable;
  logic [2:0]        read_addr;
`ifdef SEQ_STEP_EN
  logic              step;
`endif

  modport slave (
    input  load_en, load_addr, load_data, start, prog_len,
`ifdef SEQ_STEP_EN
    input  step,
`endif
    output busy, done, pc, A, B, opcode, write_addr, write_enable, read_addr
  );

  modport master (
    output load_en, load_addr, load_data, start, prog_len,
`ifdef SEQ_STEP_EN
    output step,
`endif
    input  busy, done, pc, A, B, opcode, write_addr, write_enable, read_addr
  );

endinterface

// File: rtl/alu_seq_prog_mem.sv
// alu_seq_prog_mem: DEPTH x W program store, synchronous write and
// synchronous read, no reset.
//   we/waddr/wdata : write port
//   raddr/rdata    : read port, rdata valid the cycle after raddr
// A write and read of the same address in one cycle returns the new word,
// so a program word loaded alongside start is seen by the first fetch.
module alu_seq_prog_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 24,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= (we && waddr == raddr) ? wdata : mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/alu_instr_sequencer.sv
// alu_instr_sequencer: steps through a loaded program of ALU instructions,
// one FETCH and one EXEC cycle per instruction, under start/busy/done.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : alu_instr_sequencer_if.slave (load port, run control, status,
//         processor control outputs)
// Optional macro SEQ_STEP_EN: EXEC waits for bus.step before writing and
// advancing.
module alu_instr_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int PC_W = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  alu_instr_sequencer_if.slave bus
);

  localparam logic [PC_W:0] DEPTH_L = (PC_W+1)'(DEPTH);
  localparam logic [PC_W:0] ONE_L   = (PC_W+1)'(1);

  seq_state_t      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W:0]   len_q, len_d;
  instr_t          ir_q, ir_d;
  logic [PC_W:0]   len_clamped;
  logic [INSTR_W-1:0] rd_data;
  logic            mem_we;
  logic            step_ok;

`ifdef SEQ_STEP_EN
  assign step_ok = bus.step;
`else
  assign step_ok = 1'b1;
`endif

  assign len_clamped = (bus.prog_len > DEPTH_L) ? DEPTH_L : bus.prog_len;
  assign mem_we      = bus.load_en && (state_q == S_IDLE);

  // Read address is the next pc, so the registered read data already holds
  // mem[pc] while in FETCH.
  alu_seq_prog_mem #(.DEPTH(DEPTH), .W(INSTR_W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (bus.load_addr),
    .wdata (bus.load_data),
    .raddr (pc_d),
    .rdata (rd_data)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          len_d   = len_clamped;
          pc_d    = '0;
          state_d = (len_clamped == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        ir_d    = instr_t'(rd_data);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (step_ok) begin
          // len_q >= 1 here, so len_q-1 never underflows; pc never wraps.
          if ({1'b0, pc_q} == len_q - ONE_L) begin
            state_d = S_DONE;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      ir_q    <= ir_d;
    end
  end

  assign bus.busy         = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign bus.done         = (state_q == S_DONE);
  assign bus.write_enable = (state_q == S_EXEC) && step_ok;
  assign bus.pc           = pc_q;
  assign bus.A            = ir_q.a;
  assign bus.B            = ir_q.b;
  assign bus.opcode       = ir_q.opc;
  assign bus.write_addr   = ir_q.waddr;
  assign bus.read_addr    = ir_q.raddr;

endmodule

// File: doc/alu_instr_sequencer.md
Name: alu_instr_sequencer

Overview:
Upstream control stage for the 8-bit ALU/register-file processor. Holds a small loadable program of ALU instructions and steps through it under a start/busy/done handshake. For each instruction it drives the processor's A, B, opcode, write_addr, write_enable and read_addr ports. Each instruction takes two cycles: fetch, then execute.

Parameters:
DEPTH, 16, number of program words; must be a power of two and at least 2
PC_W, $clog2(DEPTH), program-counter width; derived, not overridden

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous, active-high reset
load_en  input  1  program-memory write strobe; honoured only in IDLE
load_addr  input  PC_W  program word address
load_data  input  24  instruction word: [23:22] opcode, [21:19] write_addr, [18:16] read_addr, [15:8] A, [7:0] B
start  input  1  run request; sampled only in IDLE
prog_len  input  PC_W+1  number of instructions to run; sampled with start
busy  output  1  high from the first FETCH through the last EXEC
done  output  1  one-cycle pulse after the last instruction
pc  output  PC_W  current program counter
A  output  8  ALU operand A
B  output  8  ALU operand B
opcode  output  2  ALU opcode
write_addr  output  3  register-file write address
write_enable  output  1  register-file write strobe
read_addr  output  3  register-file read address

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high.
- States: IDLE, FETCH, EXEC, DONE.
- Reset: state=IDLE, pc=0, IR=0, len_q=0, busy=0, done=0, write_enable=0. A, B, opcode, write_addr and read_addr are all 0. Program memory is not cleared.
- IDLE:
  - load_en writes load_data to mem[load_addr].
  - If start=1, latch len_q = min(prog_len, DEPTH) and clear pc.
  - Next state is DONE if the clamped length is 0, otherwise FETCH.
- FETCH: IR <= mem[pc]; next state EXEC.
- EXEC:
  - write_enable=1 for exactly this cycle. A, B, opcode, write_addr and read_addr present the IR fields.
  - If pc == len_q-1, go to DONE. Otherwise pc <= pc+1 and go to FETCH.
- DONE: done=1 for one cycle; next state IDLE. pc holds the last executed index.
- Field outputs are driven from IR in every state and hold after completion. write_enable is high only in EXEC.
- Timing: start sampled at edge e0 with N≥1 gives:
  - busy high in cycles 1..2N
  - EXEC cycles at 2, 4, …, 2N
  - done in cycle 2N+1
  - N=0 gives done in cycle 1, busy never asserts, no writes.
- Boundaries:
  - start or load_en while not IDLE: ignored.
  - load_en and start in the same IDLE cycle: both accepted; the first FETCH sees the new word.
  - prog_len > DEPTH: clamped to DEPTH.
  - pc does not wrap within a run.
  - rst mid-run: immediate return to IDLE on that edge, write_enable deasserts, no done pulse.

Optional Feature:
SEQ_STEP_EN
- Defined: adds input step (1 bit). EXEC holds until step=1.
  - write_enable=step while in EXEC, so exactly one write per instruction.
  - pc advances or DONE is entered on the step cycle.
  - busy remains high while waiting.
- Undefined: no step port; EXEC always lasts one cycle.

Decomposition:
- Package alu_seq_pkg:
  - INSTR_W=24
  - field offset/width constants: OPC_LSB=22, WADDR_LSB=19, RADDR_LSB=16, A_LSB=8, B_LSB=0
  - opcode constants OP_AND=0, OP_OR=1, OP_NAND=2, OP_NOR=3
  - state enum seq_state_t
- Sub-module alu_seq_prog_mem: DEPTH×INSTR_W, synchronous write, synchronous read, no reset.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> all outputs 0, state IDLE, no write_enable for 10 cycles.
- Single instruction: load word0 = {OP_AND, w=1, r=1, A=F0, B=3C}; start, prog_len=1.
  - Cycle 2: write_enable=1, A=F0, B=3C, opcode=0, write_addr=1.
  - Cycle 3: done=1.
  - Processor read of reg 1 returns 30.
- Three-instruction run {OR → r2, NAND → r3, NOR → r4} with A=0F, B=F0.
  - Writes in cycles 2, 4, 6; reg2=FF, reg3=FF, reg4=00.
  - busy in cycles 1–6; done in cycle 7.
- Edge lengths:
  - prog_len=0 -> done in cycle 1, zero writes.
  - prog_len=31 with DEPTH=16 -> 16 writes, done in cycle 33.
- Interference: start, and load_en to address 0, issued during busy -> ignored; mem[0] is unchanged on the next run. rst in cycle 3 of a 4-instruction run -> IDLE next cycle, no done pulse, only one write seen.
- SEQ_STEP_EN: 2-instruction run with step pulses at cycles 5 and 9 -> writes only in cycles 5 and 9; busy is high throughout.
